apb_fifo_reader: RTL and testbench

APB slave that drains the read side of the show-ahead asynchronous FIFO into CPU-visible registers. The block sits in the FIFO's read-clock domain. A read of the DATA register pops one word, and the popped word is returned on prdata. It also exposes FIFO status, a pop counter and an underflow flag. With the timeout feature compiled in, an empty-FIFO read inserts wait states until data arrives or a timeout expires.

---
 rtl/apb_fifo_reader.sv | 181 ++++++++++++++++++
 tb/tb_apb_fifo_reader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_fifo_reader.sv
// APB slave that pops a show-ahead async FIFO (read-clock domain) into CPU-visible registers.
// Define APB_FIFO_RD_TIMEOUT_EN to let an empty DATA read wait up to TIMEOUT cycles for data.
module apb_fifo_reader #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [3:0]            paddr,
    input  logic [31:0]           pwdata,
    output logic [31:0]           prdata,
    output logic                  pready,
    output logic                  pslverr,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    input  logic                  fifo_full,
    output logic                  fifo_rd_en
);

`ifdef APB_FIFO_RD_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
    localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
`else
    typedef enum logic [1:0] {IDLE, RESP} state_e;
`endif

    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_CTRL   = 2'd2;

    state_e               state_q, state_d;
    logic [31:0]          prdata_q, prdata_d;
    logic                 pready_q, pready_d;
    logic                 pslverr_q, pslverr_d;
    logic                 enable_q, enable_d;
    logic                 underflow_q, underflow_d;
    logic [CNT_WIDTH-1:0] pop_cnt_q, pop_cnt_d;

    logic        pop;
    logic        clear;
    logic [31:0] head_word;
    logic [31:0] status_word;
    logic [31:0] ctrl_word;
    logic        unused_ok;

    assign unused_ok = ^{pwdata[31:2], paddr[1:0], 32'(TIMEOUT)};
    assign head_word = 32'(fifo_dout);
    assign ctrl_word = {31'd0, enable_q};

    always_comb begin
        status_word                  = '0;
        status_word[0]               = fifo_empty;
        status_word[1]               = fifo_full;
        status_word[2]               = underflow_q;
        status_word[3]               = enable_q;
        status_word[16 +: CNT_WIDTH] = pop_cnt_q;
    end

    // NOTE: every _d gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        prdata_d    = '0;
        pready_d    = 1'b0;
        pslverr_d   = 1'b0;
        enable_d    = enable_q;
        underflow_d = underflow_q;
        pop         = 1'b0;
        clear       = 1'b0;
`ifdef APB_FIFO_RD_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (psel && penable) begin
                    state_d  = RESP;
                    pready_d = 1'b1;
                    case (paddr[3:2])
                        A_DATA: begin
                            if (pwrite || !enable_q) begin
                                pslverr_d = 1'b1;
                            end else if (!fifo_empty) begin
                                pop      = 1'b1;
                                prdata_d = head_word;
                            end else begin
`ifdef APB_FIFO_RD_TIMEOUT_EN
                                state_d    = WAIT;
                                pready_d   = 1'b0;
                                wait_cnt_d = '0;
`else
                                pslverr_d   = 1'b1;
                                underflow_d = 1'b1;
`endif
                            end
                        end
                        A_STATUS: begin
                            if (pwrite) pslverr_d = 1'b1;
                            else        prdata_d  = status_word;
                        end
                        A_CTRL: begin
                            if (pwrite) begin
                                enable_d = pwdata[0];
                                clear    = pwdata[1];
                            end else begin
                                prdata_d = ctrl_word;
                            end
                        end
                        default: pslverr_d = 1'b1;
                    endcase
                end
            end
`ifdef APB_FIFO_RD_TIMEOUT_EN
            WAIT: begin
                wait_cnt_d = wait_cnt_q + 1'b1;
                // An abort takes priority so a dropped transfer never consumes a word.
                if (!psel) begin
                    state_d = IDLE;
                end else if (!fifo_empty) begin
                    pop      = 1'b1;
                    prdata_d = head_word;
                    state_d  = RESP;
                    pready_d = 1'b1;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d     = RESP;
                    pready_d    = 1'b1;
                    pslverr_d   = 1'b1;
                    underflow_d = 1'b1;
                end
            end
`endif
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        pop_cnt_d = pop ? pop_cnt_q + 1'b1 : pop_cnt_q;
        if (clear) begin
            pop_cnt_d   = '0;
            underflow_d = 1'b0;
        end
    end

    // Gated by rst so an abandoned transfer cannot pop while reset is applied.
    assign fifo_rd_en = pop && !rst;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            prdata_q    <= '0;
            pready_q    <= 1'b0;
            pslverr_q   <= 1'b0;
            enable_q    <= 1'b0;
            underflow_q <= 1'b0;
            pop_cnt_q   <= '0;
`ifdef APB_FIFO_RD_TIMEOUT_EN
            wait_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            prdata_q    <= prdata_d;
            pready_q    <= pready_d;
            pslverr_q   <= pslverr_d;
            enable_q    <= enable_d;
            underflow_q <= underflow_d;
            pop_cnt_q   <= pop_cnt_d;
`ifdef APB_FIFO_RD_TIMEOUT_EN
            wait_cnt_q  <= wait_cnt_d;
`endif
        end
    end

    assign prdata  = prdata_q;
    assign pready  = pready_q;
    assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_fifo_reader.sv
// Directed bench for apb_fifo_reader; a small FIFO model supplies the show-ahead read side.
module tb_apb_fifo_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [3:0]  paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic [15:0] fifo_dout;
    logic        fifo_empty;
    logic        fifo_full = 1'b0;
    logic        fifo_rd_en;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] fifo_mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_dout  = fifo_mem[rd_ptr % 64];

    always @(posedge clk) if (fifo_rd_en) rd_ptr <= rd_ptr + 1;

    always #5 clk = ~clk;

    apb_fifo_reader #(.DATA_WIDTH(16), .CNT_WIDTH(4), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .fifo_full(fifo_full), .fifo_rd_en(fifo_rd_en)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] w);
        fifo_mem[wr_ptr % 64] = w;
        wr_ptr++;
    endtask

    // One APB transfer; lat counts access-phase edges up to and including the one raising pready.
    task automatic apb(input logic [3:0] addr, input logic wr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err, output int lat,
                       output int npop, output logic rd_a1);
        int p0;
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        @(negedge clk);
        penable = 1'b1;
        p0 = rd_ptr;
        #1 rd_a1 = fifo_rd_en;
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!pready && lat < 64);
        rdata = prdata;
        err   = pslverr;
        @(posedge clk); #1;
        npop = rd_ptr - p0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er, a1;
        int          lat, np, p0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_prdata", prdata, 32'h0);
        check("rst_pready", {31'd0, pready}, 32'h0);
        check("rst_pslverr", {31'd0, pslverr}, 32'h0);
        check("rst_rd_en", {31'd0, fifo_rd_en}, 32'h0);
        @(negedge clk) rst = 1'b0;

        // Disabled DATA read with data present: error, no pop.
        push(16'hBEEF);
        apb(4'h0, 1'b0, 32'h0, rd, er, lat, np, a1);
        check("dis_err", {31'd0, er}, 32'h1);
        check("dis_prdata", rd, 32'h0);
        check("dis_npop", 32'(np), 32'h0);
        check("dis_rd_a1", {31'd0, a1}, 32'h0);
        apb(4'h4, 1'b0, 32'h0, rd, er, lat, np, a1);
        check("status0", rd, 32'h0000_0000);

        apb(4'h8, 1'b1, 32'h1, rd, er, lat, np, a1);
        check("ctrl_wr_err", {31'd0, er}, 32'h0);
        apb(4'h8, 1'b0, 32'h0, rd, er, lat, np, a1);
        check("ctrl_rd", rd, 32'h1);

        apb(4'h0, 1'b0, 32'h0, rd, er, lat, np, a1);
        check("beef_data", rd, 32'h0000_BEEF);
        check("beef_err", {31'd0, er}, 32'h0);
        check("beef_rd_a1", {31'd0, a1}, 32'h1);
        check("beef_npop", 32'(np), 32'h1);
        check("beef_lat", 32'(lat), 32'h1);
        apb(4'h4, 1'b0, 32'h0, rd, er, lat, np, a1);
        check("status1", rd, 32'h0001_0009);

        // 15 more pops bring the 4-bit counter to 16 -> 0, then one more -> 1.
        for (int i = 0; i < 15; i++) push(16'h1000 + 16'(i));
        for (int i = 0; i < 15; i++) begin
            apb(4'h0, 1'b0, 32'h0, rd, er, lat, np, a1);
            check($sformatf("burst_%0d", i), rd, 32'h1000 + 32'(i));
        end
        apb(4'h4, 1'b0, 32'h0, rd, er, lat, np, a1);
        check("status_wrap0", rd, 32'h0000_0009);
        push(16'h2222);
        apb(4'h0, 1'b0, 32'h0, rd, er, lat, np, a1);
        check("data_2222", rd, 32'h0000_2222);
        apb(4'h4, 1'b0, 32'h0, rd, er, lat, np, a1);
        check("status_wrap1", rd, 32'h0001_0009);

        // Illegal accesses with data present: error, zero data, no pop.
        push(16'h5A5A);
        apb(4'h0, 1'b1, 32'hFFFF_FFFF, rd, er, lat, np, a1);
        check("wr_data_err", {31'd0, er}, 32'h1);
        check("wr_data_npop", 32'(np), 32'h0);
        apb(4'hC, 1'b0, 32'h0, rd, er, lat, np, a1);
        check("rd_c_err", {31'd0, er}, 32'h1);
        check("rd_c_prdata", rd, 32'h0);
        check("rd_c_npop", 32'(np), 32'h0);
        apb(4'hC, 1'b1, 32'h1, rd, er, lat, np, a1);
        check("wr_c_err", {31'd0, er}, 32'h1);
        apb(4'h4, 1'b1, 32'h1, rd, er, lat, np, a1);
        check("wr_status_err", {31'd0, er}, 32'h1);
        apb(4'h0, 1'b0, 32'h0, rd, er, lat, np, a1);
        check("data_5a5a", rd, 32'h0000_5A5A);

        fifo_full = 1'b1;
        apb(4'h4, 1'b0, 32'h0, rd, er, lat, np, a1);
        check("status_full", rd, 32'h0002_000B);
        fifo_full = 1'b0;

`ifdef APB_FIFO_RD_TIMEOUT_EN
        // Empty read; data arrives during the 5th WAIT cycle.
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 4'h0;
        @(negedge clk);
        penable = 1'b1;
        p0 = rd_ptr;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        check("wait_pready", {31'd0, pready}, 32'h0);
        push(16'h1234);
        #1 check("wait_rd_en", {31'd0, fifo_rd_en}, 32'h1);
        @(posedge clk); #1;
        check("late_pready", {31'd0, pready}, 32'h1);
        check("late_data", prdata, 32'h0000_1234);
        check("late_err", {31'd0, pslverr}, 32'h0);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        check("late_npop", 32'(rd_ptr - p0), 32'h1);

        apb(4'h0, 1'b0, 32'h0, rd, er, lat, np, a1);
        check("tmo_lat", 32'(lat), 32'd16);
        check("tmo_err", {31'd0, er}, 32'h1);
        check("tmo_prdata", rd, 32'h0);
        check("tmo_npop", 32'(np), 32'h0);
        apb(4'h4, 1'b0, 32'h0, rd, er, lat, np, a1);
        check("status_uf", rd, 32'h0003_000D);
`else
        apb(4'h0, 1'b0, 32'h0, rd, er, lat, np, a1);
        check("empty_lat", 32'(lat), 32'd1);
        check("empty_err", {31'd0, er}, 32'h1);
        check("empty_prdata", rd, 32'h0);
        check("empty_npop", 32'(np), 32'h0);
        apb(4'h4, 1'b0, 32'h0, rd, er, lat, np, a1);
        check("status_uf", rd, 32'h0002_000D);
`endif

        apb(4'h8, 1'b1, 32'h3, rd, er, lat, np, a1);
        apb(4'h4, 1'b0, 32'h0, rd, er, lat, np, a1);
        check("status_clr", rd, 32'h0000_0009);
        apb(4'h8, 1'b0, 32'h0, rd, er, lat, np, a1);
        check("ctrl_after_clr", rd, 32'h1);

        // Reset in the middle of an empty DATA read, with data arriving as reset rises.
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 4'h0;
        @(negedge clk);
        penable = 1'b1;
        p0 = rd_ptr;
        @(posedge clk); #1;
        rst = 1'b1;
        push(16'h7777);
        #1 check("rst_mid_rd_en", {31'd0, fifo_rd_en}, 32'h0);
        @(posedge clk); #1;
        check("rst_mid_pready", {31'd0, pready}, 32'h0);
        check("rst_mid_prdata", prdata, 32'h0);
        check("rst_mid_pslverr", {31'd0, pslverr}, 32'h0);
        psel = 1'b0; penable = 1'b0;
        @(negedge clk) rst = 1'b0;
        check("rst_mid_npop", 32'(rd_ptr - p0), 32'h0);
        apb(4'h4, 1'b0, 32'h0, rd, er, lat, np, a1);
        check("status_post_rst", rd, 32'h0000_0000);
        apb(4'h8, 1'b1, 32'h1, rd, er, lat, np, a1);
        apb(4'h0, 1'b0, 32'h0, rd, er, lat, np, a1);
        check("post_rst_data", rd, 32'h0000_7777);
        check("post_rst_err", {31'd0, er}, 32'h0);
        check("post_rst_npop", 32'(np), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
